// File: rtl/axil_master.sv
// axil_master: single-outstanding AXI-Lite initiator driven by a valid/ready
// command port; returns read data and an error flag on a valid/ready response port.
// Ports: aclk, areset (async, active-high); cmd_* in / cmd_ready out;
//   rsp_* out / rsp_ready in; AW, W, B, AR, R AXI-Lite channels.
// Option: define AXIL_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog.
module axil_master #(
  parameter int DATA_WIDTH          = 16,
  parameter int AXI_LITE_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES      = 256
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_write,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]          cmd_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic                           rsp_timeout,
  output logic [AXI_LITE_ADDR_WIDTH-1:0] awaddr,
  output logic                           awvalid,
  input  logic                           awready,
  output logic [DATA_WIDTH-1:0]          wdata,
  output logic                           wvalid,
  input  logic                           wready,
  input  logic [1:0]                     bresp,
  input  logic                           bvalid,
  output logic                           bready,
  output logic [AXI_LITE_ADDR_WIDTH-1:0] araddr,
  output logic                           arvalid,
  input  logic                           arready,
  input  logic [DATA_WIDTH-1:0]          rdata,
  input  logic [1:0]                     rresp,
  input  logic                           rvalid,
  output logic                           rready
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = AXI_LITE_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            arvalid_q, arvalid_d;
  logic            bready_q, bready_d;
  logic            rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_timeout_q, rsp_timeout_d;

  logic aw_hs, w_hs, aw_done, w_done;
  logic expired, abort;

  assign aw_hs   = awvalid_q & awready;
  assign w_hs    = wvalid_q & wready;
  // a channel is done once its valid has dropped or it handshakes now
  assign aw_done = ~awvalid_q | aw_hs;
  assign w_done  = ~wvalid_q | w_hs;

`ifdef AXIL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy;

  assign busy    = (state_q != S_IDLE) && (state_q != S_RESP);
  assign expired = busy && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) cnt_d = '0;
    else if (busy)         cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  // watchdog compiled out: never fires
  assign expired = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    bready_d      = bready_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    abort         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (bvalid && bready_q) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = bresp[1];
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      S_RD_ADDR: begin
        if (arready && arvalid_q) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (rvalid && rready_q) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = rdata;
          rsp_err_d     = rresp[1];
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      bready_d      = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b1;
      state_d       = S_RESP;
    end
  end

  // cmd_ready comes up one cycle after reset release
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= (state_d == S_IDLE);
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  logic unused_ready_d;
  assign unused_ready_d = cmd_ready_d;

  assign cmd_ready   = cmd_ready_q;
  assign awaddr      = addr_q;
  assign araddr      = addr_q;
  assign wdata       = wdata_q;
  assign awvalid     = awvalid_q;
  assign wvalid      = wvalid_q;
  assign arvalid     = arvalid_q;
  assign bready      = bready_q;
  assign rready      = rready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_axil_master.sv
// tb_axil_master: scoreboard bench for axil_master against a behavioural
// AXI-Lite register-file responder with programmable channel delays.
module tb_axil_master;

  localparam int DW = 16;
  localparam int AW = 8;
`ifdef AXIL_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif

  logic          aclk, areset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready;
  logic [DW-1:0] wdata, rdata;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready, rvalid, rready;

  axil_master #(
    .DATA_WIDTH(DW),
    .AXI_LITE_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- responder ----------------
  logic [DW-1:0] mem [64];
  int            aw_dly, w_dly, ar_dly;
  bit            b_stall, ar_stuck;
  int            aw_wait, w_wait, ar_wait;
  bit            aw_have, w_have;
  logic [AW-1:0] aw_addr_r;
  logic [DW-1:0] w_data_r;

  assign awready = awvalid && !aw_have && (aw_wait >= aw_dly);
  assign wready  = wvalid && !w_have && (w_wait >= w_dly);
  assign arready = arvalid && !rvalid && !ar_stuck
                   && (ar_wait >= ar_dly);

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_have <= 0; w_have <= 0;
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      bvalid <= 0; bresp <= 0;
      rvalid <= 0; rresp <= 0; rdata <= 0;
      aw_addr_r <= 0; w_data_r <= 0;
      for (int i = 0; i < 64; i++)
        mem[i] <= (i == 1) ? 16'd250 : 16'(i * 16'h0101);
    end else begin
      if (awvalid && awready) begin
        aw_have <= 1; aw_addr_r <= awaddr; aw_wait <= 0;
      end else if (awvalid && !aw_have) begin
        aw_wait <= aw_wait + 1;
      end
      if (wvalid && wready) begin
        w_have <= 1; w_data_r <= wdata; w_wait <= 0;
      end else if (wvalid && !w_have) begin
        w_wait <= w_wait + 1;
      end
      if (aw_have && w_have && !bvalid && !b_stall) begin
        if (aw_addr_r == 8'hFC) begin
          bresp <= 2'b10;
        end else begin
          bresp <= 2'b00;
          mem[aw_addr_r[7:2]] <= w_data_r;
        end
        bvalid <= 1; aw_have <= 0; w_have <= 0;
      end
      if (bvalid && bready) bvalid <= 0;
      if (arvalid && arready) begin
        rvalid  <= 1;
        ar_wait <= 0;
        if (araddr == 8'hFC) begin
          rresp <= 2'b10; rdata <= '0;
        end else begin
          rresp <= 2'b00; rdata <= mem[araddr[7:2]];
        end
      end else if (arvalid && !rvalid) begin
        ar_wait <= ar_wait + 1;
      end
      if (rvalid && rready) rvalid <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t got;
  int   tests, fails;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(logic [DW-1:0] rd, logic e, logic t);
    exp_q.push_back('{rdata: rd, err: e, tmo: t});
  endtask

  always @(negedge aclk) begin
    if (!areset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        got = exp_q.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), 32'(got.rdata));
        check("rsp_err", 32'(rsp_err), 32'(got.err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(got.tmo));
      end
    end
  end

  // ---------------- channel monitor ----------------
  bit            prev_aw, prev_w, prev_ar;
  int            viol, b_hs_cnt;
  bit            saw_w_only;
  logic [AW-1:0] last_awaddr, last_araddr;
  logic [DW-1:0] last_wdata;

  always @(negedge aclk) begin
    if (areset) begin
      prev_aw = 0; prev_w = 0; prev_ar = 0;
    end else begin
      if (!rsp_timeout) begin
        if (prev_aw && !awvalid) viol++;
        if (prev_w && !wvalid)   viol++;
        if (prev_ar && !arvalid) viol++;
      end
      prev_aw = awvalid && !awready;
      prev_w  = wvalid && !wready;
      prev_ar = arvalid && !arready;
      if (awvalid && awready) last_awaddr = awaddr;
      if (wvalid && wready)   last_wdata = wdata;
      if (arvalid && arready) last_araddr = araddr;
      if (bvalid && bready)   b_hs_cnt++;
      if (awvalid && !wvalid) saw_w_only = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
    @(posedge aclk); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    for (int n = 0; ; n++) begin
      @(negedge aclk);
      if (cmd_ready) break;
      if (n > 100) begin
        check("cmd_accept_wait", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge aclk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_done();
    for (int n = 0; ; n++) begin
      @(negedge aclk);
      if (exp_q.size() == 0 && cmd_ready) break;
      if (n > 200) begin
        check("rsp_wait", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  logic [31:0] snap;

  initial begin
    #200000;
    $display("FAIL global_watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; viol = 0; b_hs_cnt = 0;
    saw_w_only = 0;
    aw_dly = 0; w_dly = 0; ar_dly = 0;
    b_stall = 0; ar_stuck = 0;
    areset = 1; cmd_valid = 0; cmd_write = 0;
    cmd_addr = 0; cmd_wdata = 0; rsp_ready = 1;
    repeat (3) @(posedge aclk);
    #1;
    check("reset_ctrl",
          {awvalid, wvalid, arvalid, bready, rready, rsp_valid,
           rsp_err, rsp_timeout}, 32'd0);
    check("reset_data", {awaddr, araddr, wdata}, 32'd0);
    check("reset_rdata", 32'(rsp_rdata), 32'd0);
    areset = 0;

    // 1: write 0x1234 to 0x08
    b_hs_cnt = 0;
    expect_rsp(16'h0000, 0, 0);
    issue(1, 8'h08, 16'h1234);
    wait_done();
    check("wr_awaddr", 32'(last_awaddr), 32'h08);
    check("wr_wdata", 32'(last_wdata), 32'h1234);
    check("wr_b_handshakes", b_hs_cnt, 1);

    // 2: read back, read reset content
    expect_rsp(16'h1234, 0, 0);
    issue(0, 8'h08, 16'h0);
    wait_done();
    check("rd_araddr", 32'(last_araddr), 32'h08);
    expect_rsp(16'd250, 0, 0);
    issue(0, 8'h04, 16'h0);
    wait_done();

    // 3: W accepted 3 cycles before AW
    aw_dly = 3; b_hs_cnt = 0; saw_w_only = 0;
    expect_rsp(16'h0000, 0, 0);
    issue(1, 8'h20, 16'hA5A5);
    wait_done();
    check("w_before_aw_seen", 32'(saw_w_only), 32'd1);
    check("w_before_aw_b_hs", b_hs_cnt, 1);
    aw_dly = 0; w_dly = 2; ar_dly = 2;
    expect_rsp(16'h0000, 0, 0);
    issue(1, 8'h24, 16'h0F0F);
    expect_rsp(16'hA5A5, 0, 0);
    issue(0, 8'h20, 16'h0);
    expect_rsp(16'h0F0F, 0, 0);
    issue(0, 8'h24, 16'h0);
    wait_done();
    w_dly = 0; ar_dly = 0;

    // 4: error responses and response back-pressure
    expect_rsp(16'h0000, 1, 0);
    issue(1, 8'hFC, 16'h5555);
    wait_done();
    @(posedge aclk); #1;
    rsp_ready = 0;
    expect_rsp(16'h0000, 1, 0);
    issue(0, 8'hFC, 16'h0);
    for (int n = 0; ; n++) begin
      @(negedge aclk);
      if (rsp_valid) break;
      if (n > 100) begin
        check("rsp_valid_wait", 32'd0, 32'd1);
        break;
      end
    end
    snap = {rsp_valid, rsp_timeout, rsp_err, 13'd0, rsp_rdata};
    check("err_rsp_flags", snap[31:29], 3'b101);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("rsp_stable",
            {rsp_valid, rsp_timeout, rsp_err, 13'd0, rsp_rdata},
            snap);
    end
    @(posedge aclk); #1;
    rsp_ready = 1;
    wait_done();

    // 5: reset while waiting in WR_RESP
    b_stall = 1;
    issue(1, 8'h30, 16'h7777);
    for (int n = 0; ; n++) begin
      @(negedge aclk);
      if (bready) break;
      if (n > 100) begin
        check("bready_wait", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge aclk); #1;
    areset = 1;
    #1;
    check("reset_mid_ctrl",
          {awvalid, wvalid, arvalid, bready, rready, rsp_valid},
          32'd0);
    @(posedge aclk); @(posedge aclk); #1;
    areset = 0; b_stall = 0;
    for (int n = 0; ; n++) begin
      @(negedge aclk);
      if (cmd_ready || n >= 3) break;
    end
    check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
    expect_rsp(16'd250, 0, 0);
    issue(0, 8'h04, 16'h0);
    expect_rsp(16'h0202, 0, 0);
    issue(0, 8'h08, 16'h0);
    wait_done();

`ifdef AXIL_TIMEOUT_EN
    // 6: watchdog on a stuck AR channel
    begin
      int n;
      ar_stuck = 1;
      expect_rsp(16'h0000, 1, 1);
      issue(0, 8'h10, 16'h0);
      for (n = 1; n <= 40; n++) begin
        @(posedge aclk); #1;
        if (rsp_valid) break;
      end
      check("timeout_latency", n, 16);
      wait_done();
      ar_stuck = 0;
      expect_rsp(16'h1010, 0, 0);
      issue(0, 8'h40, 16'h0);
      wait_done();
    end
`endif

    check("protocol_violations", viol, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
